// File: rtl/panzoom_seq.sv
// panzoom_seq: capture sequencer for a pan/zoom averaging datapath.
// One command runs up to three passes (mean/min/max); each is settled, armed, triggered and recorded.
module panzoom_seq #(
    parameter int MEMAW  = 10,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [5:0]       cmd_navr,
    input  logic [31:0]      cmd_dt,
    input  logic [2:0]       cmd_opmask,
    input  logic [31:0]      cmd_timeout,
    input  logic             abort,
    output logic             pz_reset,
    output logic [5:0]       pz_navr,
    output logic [31:0]      pz_dt,
    output logic [2:0]       pz_opsel,
    input  logic             pz_gout,
    input  logic [MEMAW-1:0] pz_addrcnt,
    input  logic             pz_stopped,
    output logic             wr_en,
    output logic [MEMAW+1:0] wr_addr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ARM,
        S_WAIT_TRIG,
        S_RUN,
        S_NEXT,
        S_FIN
    } state_e;

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]  ERR_ABORT   = 2'b10;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [5:0]  navr_q, navr_d;
    logic [31:0] dt_q, dt_d;
    logic [2:0]  todo_q, todo_d;
    logic [31:0] timeout_q, timeout_d;
    logic [1:0]  pass_q, pass_d;
    logic [31:0] settle_cnt_q, settle_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]  err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            navr_q       <= '0;
            dt_q         <= '0;
            todo_q       <= '0;
            timeout_q    <= '0;
            pass_q       <= '0;
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            err_q        <= ERR_OK;
        end else begin
            state_q      <= state_d;
            navr_q       <= navr_d;
            dt_q         <= dt_d;
            todo_q       <= todo_d;
            timeout_q    <= timeout_d;
            pass_q       <= pass_d;
            settle_cnt_q <= settle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        navr_d       = navr_q;
        dt_d         = dt_q;
        todo_d       = todo_q;
        timeout_d    = timeout_q;
        pass_d       = pass_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    navr_d    = cmd_navr;
                    dt_d      = cmd_dt;
                    todo_d    = cmd_opmask;
                    timeout_d = cmd_timeout;
                    pass_d    = '0;
                    err_d     = ERR_OK;
                    state_d   = S_NEXT;
                end
            end
            S_NEXT: begin
                // todo_q holds the passes not yet run; lowest bit goes first
                settle_cnt_d = '0;
                if (todo_q[0]) begin
                    pass_d    = 2'd0;
                    todo_d[0] = 1'b0;
                    state_d   = S_SETTLE;
                end else if (todo_q[1]) begin
                    pass_d    = 2'd1;
                    todo_d[1] = 1'b0;
                    state_d   = S_SETTLE;
                end else if (todo_q[2]) begin
                    pass_d    = 2'd2;
                    todo_d[2] = 1'b0;
                    state_d   = S_SETTLE;
                end else begin
                    state_d   = S_FIN;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_ARM;
                end else begin
                    settle_cnt_d = settle_cnt_q + 32'd1;
                end
            end
            S_ARM: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                if (!pz_stopped) begin
                    state_d = S_RUN;
                end else if ((timeout_q != '0) && (wait_cnt_q == timeout_q - 32'd1)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_FIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                if (pz_stopped) begin
                    state_d = S_NEXT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            err_d   = ERR_ABORT;
        end
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        pz_reset  = (state_q == S_ARM);
        // the sample that arrives with the stop edge is still in RUN, so it is written
        wr_en     = (state_q == S_RUN) && pz_gout;
        done      = (state_q == S_FIN) && !abort;
    end

    assign wr_addr  = {pass_q, pz_addrcnt};
    assign pz_navr  = navr_q;
    assign pz_dt    = dt_q;
    assign pz_opsel = {1'b0, pass_q};
    assign err      = err_q;

endmodule

// File: tb/tb_panzoom_seq.sv
// Bench for panzoom_seq: emulated datapath, vector table, hand sequences and random commands
// checked against a pass-level reference model.
module tb_panzoom_seq;

    localparam int MEMAW  = 4;
    localparam int SETTLE = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [5:0]       cmd_navr = '0;
    logic [31:0]      cmd_dt = '0;
    logic [2:0]       cmd_opmask = '0;
    logic [31:0]      cmd_timeout = '0;
    logic             abort = 1'b0;
    logic             pz_reset;
    logic [5:0]       pz_navr;
    logic [31:0]      pz_dt;
    logic [2:0]       pz_opsel;
    logic             pz_gout = 1'b0;
    logic [MEMAW-1:0] pz_addrcnt = '0;
    logic             pz_stopped = 1'b1;
    logic             wr_en;
    logic [MEMAW+1:0] wr_addr;
    logic             busy;
    logic             done;
    logic [1:0]       err;

    always #5 clk = ~clk;

    panzoom_seq #(.MEMAW(MEMAW), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_navr(cmd_navr), .cmd_dt(cmd_dt), .cmd_opmask(cmd_opmask), .cmd_timeout(cmd_timeout),
        .abort(abort), .pz_reset(pz_reset), .pz_navr(pz_navr), .pz_dt(pz_dt), .pz_opsel(pz_opsel),
        .pz_gout(pz_gout), .pz_addrcnt(pz_addrcnt), .pz_stopped(pz_stopped),
        .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Datapath emulation: after each arm pulse, trigger (stopped falls) trig_d cycles later,
    // then emit nwr samples; the last sample coincides with the stop edge. trig_d==0: never.
    int unsigned trig_d = 1;
    int unsigned nwr = 1;
    int          dp_phase = 0;
    int unsigned dp_cnt = 0;
    int unsigned dp_wc = 0;

    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            dp_phase = 0; pz_stopped = 1'b1; pz_gout = 1'b0; pz_addrcnt = '0;
        end else if (pz_reset) begin
            dp_phase = 1; dp_cnt = 0; dp_wc = 0;
            pz_stopped = 1'b1; pz_gout = 1'b0; pz_addrcnt = '0;
        end else begin
            case (dp_phase)
                1: begin
                    dp_cnt++;
                    if (trig_d != 0 && dp_cnt == trig_d) begin
                        pz_stopped = 1'b0;
                        dp_phase = 2;
                    end
                end
                2: begin
                    if (pz_gout) begin
                        pz_addrcnt++;
                        dp_wc++;
                    end
                    if (dp_wc == nwr - 1) begin
                        pz_gout = 1'b1; pz_stopped = 1'b1; dp_phase = 3;
                    end else begin
                        pz_gout = 1'($urandom_range(0, 1));
                    end
                end
                3: begin
                    pz_gout = 1'b0; dp_phase = 0;
                end
                default: ;
            endcase
        end
    end

    // Reference model: expected arm pulses, written addresses and status of one command.
    logic [MEMAW+1:0] exp_addr[$];
    logic [2:0]       exp_opsel[$];
    logic [1:0]       exp_err;

    task automatic model(input logic [2:0] om, input logic [31:0] to,
                         input int unsigned td, input int unsigned nw);
        exp_addr.delete(); exp_opsel.delete(); exp_err = 2'b00;
        for (int p = 0; p < 3; p++) begin
            if (om[p]) begin
                exp_opsel.push_back(3'(p));
                if (td == 0 || (to != 0 && td > to)) begin
                    exp_err = 2'b01;
                    break;
                end
                for (int i = 0; i < int'(nw); i++) exp_addr.push_back((MEMAW+2)'((p << MEMAW) + i));
            end
        end
    endtask

    logic [MEMAW+1:0] got_addr[$];
    logic [2:0]       got_opsel[$];
    int               got_done;
    logic [1:0]       got_err;
    bit               hold_bad;

    task automatic start_cmd(input logic [5:0] navr, input logic [31:0] dt, input logic [2:0] om,
                             input logic [31:0] to, input int unsigned td, input int unsigned nw);
        trig_d = td; nwr = nw;
        @(negedge clk);
        cmd_navr = navr; cmd_dt = dt; cmd_opmask = om; cmd_timeout = to; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] navr, input logic [31:0] dt, input logic [2:0] om,
                           input logic [31:0] to, input int unsigned td, input int unsigned nw);
        got_addr.delete(); got_opsel.delete(); got_done = 0; hold_bad = 0;
        start_cmd(navr, dt, om, to, td, nw);
        for (int c = 0; c < 3000; c++) begin
            if (pz_reset) got_opsel.push_back(pz_opsel);
            if (wr_en) got_addr.push_back(wr_addr);
            if (done) got_done++;
            if (busy && (pz_navr !== navr || pz_dt !== dt)) hold_bad = 1;
            if (!busy) break;
            @(negedge clk);
        end
        chk("cmd_completes", busy, 1'b0);
        got_err = err;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) got_done++;
        end
    endtask

    task automatic compare_model(input string tag);
        int m;
        chk({tag, "_n_arm"}, got_opsel.size(), exp_opsel.size());
        m = 0;
        foreach (exp_opsel[i]) if (i >= got_opsel.size() || got_opsel[i] !== exp_opsel[i]) m++;
        chk({tag, "_opsel_mism"}, m, 0);
        chk({tag, "_n_wr"}, got_addr.size(), exp_addr.size());
        m = 0;
        foreach (exp_addr[i]) if (i >= got_addr.size() || got_addr[i] !== exp_addr[i]) m++;
        chk({tag, "_addr_mism"}, m, 0);
        chk({tag, "_err"}, got_err, exp_err);
        chk({tag, "_done_cnt"}, got_done, 1);
        chk({tag, "_hold"}, hold_bad, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 3000 && busy; c++) @(negedge clk);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    typedef struct {
        logic [5:0]  navr;
        logic [31:0] dt;
        logic [2:0]  om;
        logic [31:0] to;
        int unsigned td;
        int unsigned nw;
        int          e_arms;
        int          e_wr;
        logic [1:0]  e_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        bit seen2;

        tbl[0] = '{6'd2,  32'd5,          3'b001, 32'd0,  10, 16, 1, 16, 2'b00};
        tbl[1] = '{6'd1,  32'd7,          3'b101, 32'd0,  4,  5,  2, 10, 2'b00};
        tbl[2] = '{6'd0,  32'd0,          3'b001, 32'd50, 0,  4,  1, 0,  2'b01};
        tbl[3] = '{6'd3,  32'd9,          3'b000, 32'd0,  1,  1,  0, 0,  2'b00};
        tbl[4] = '{6'd4,  32'd1,          3'b111, 32'd5,  5,  3,  3, 9,  2'b00};
        tbl[5] = '{6'd4,  32'd1,          3'b110, 32'd5,  6,  3,  1, 0,  2'b01};
        tbl[6] = '{6'd63, 32'hFFFF_FFFF,  3'b010, 32'd1,  1,  1,  1, 1,  2'b00};
        tbl[7] = '{6'd5,  32'd2,          3'b011, 32'd0,  20, 16, 2, 32, 2'b00};

        // reset asserted between clock edges must take effect immediately
        #2 reset_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_pz_reset", pz_reset, 1'b0);
        chk("rst_outs", {pz_navr, pz_dt, pz_opsel, err}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].navr, tbl[i].dt, tbl[i].om, tbl[i].to, tbl[i].td, tbl[i].nw);
            chk($sformatf("vec%0d_arms", i), got_opsel.size(), tbl[i].e_arms);
            chk($sformatf("vec%0d_writes", i), got_addr.size(), tbl[i].e_wr);
            chk($sformatf("vec%0d_err", i), got_err, tbl[i].e_err);
            model(tbl[i].om, tbl[i].to, tbl[i].td, tbl[i].nw);
            compare_model($sformatf("vec%0d", i));
        end

        // opmask 000: done exactly two cycles after acceptance
        start_cmd(6'd1, 32'd1, 3'b000, 32'd0, 1, 1);
        chk("om0_c1_done", {busy, done}, 2'b10);
        @(negedge clk);
        chk("om0_c2_done", {busy, done, pz_reset}, 3'b110);
        @(negedge clk);
        chk("om0_c3_idle", {busy, done, err}, 4'b0000);

        // timeout of 50 cycles measured from WAIT_TRIG entry
        start_cmd(6'd0, 32'd0, 3'b001, 32'd50, 0, 4);
        n = 0;
        while (!pz_reset && n < 100) begin @(negedge clk); n++; end
        chk("to_arm_seen", pz_reset, 1'b1);
        n = 0; seen = 0;
        while (err !== 2'b01 && n < 200) begin @(negedge clk); n++; if (wr_en) seen = 1; end
        chk("to_latency", n, 51);
        chk("to_done", done, 1'b1);
        chk("to_no_wr", seen, 1'b0);
        wait_idle("to");

        // abort in the middle of RUN, then a fresh command
        start_cmd(6'd7, 32'd11, 3'b001, 32'd0, 3, 16);
        n = 0;
        while (!wr_en && n < 200) begin @(negedge clk); n++; end
        chk("ab_in_run", wr_en, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_state", {busy, err, wr_en, done}, 5'b0_10_0_0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (done || busy) seen = 1; end
        chk("ab_quiet", seen, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle_ignored", {busy, err}, 3'b0_10);
        run_cmd(6'd9, 32'd33, 3'b100, 32'd0, 2, 6);
        model(3'b100, 32'd0, 2, 6);
        compare_model("ab_next");

        // cmd_valid while busy is neither accepted nor queued
        trig_d = 2; nwr = 4;
        start_cmd(6'd2, 32'd3, 3'b001, 32'd0, 2, 4);
        n = 0; got_done = 0;
        for (int c = 0; c < 500 && busy; c++) begin
            cmd_valid = (c < 4);
            cmd_opmask = 3'b111;
            if (pz_reset) n++;
            if (done) got_done++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bz_arms", n, 1);
        chk("bz_done", got_done, 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); if (busy) seen = 1; end
        chk("bz_no_replay", seen, 1'b0);

        // asynchronous reset during RUN with cmd_valid held while busy
        start_cmd(6'd5, 32'd77, 3'b011, 32'd0, 2, 8);
        cmd_valid = 1'b1;
        n = 0;
        while (!wr_en && n < 200) begin @(negedge clk); n++; end
        chk("rr_in_run", wr_en, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rr_ctl", {cmd_ready, busy, done, wr_en, pz_reset}, 5'b10000);
        chk("rr_outs", {pz_navr, pz_dt, pz_opsel, err}, '0);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0; seen2 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) seen = 1;
            if (wr_en || done || pz_reset) seen2 = 1;
        end
        chk("rr_no_replay", seen, 1'b0);
        chk("rr_quiet", seen2, 1'b0);
        run_cmd(6'd2, 32'd5, 3'b001, 32'd0, 10, 16);
        model(3'b001, 32'd0, 10, 16);
        compare_model("rr_after");

        // randomized commands against the reference model
        for (int k = 0; k < 12; k++) begin
            logic [5:0]  rn;
            logic [31:0] rdt;
            logic [2:0]  rom;
            logic [31:0] rto;
            int unsigned rtd;
            int unsigned rnw;
            rn  = 6'($urandom);
            rdt = $urandom;
            rom = 3'($urandom_range(0, 7));
            rto = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
            rtd = $urandom_range(1, 15);
            rnw = $urandom_range(1, 16);
            run_cmd(rn, rdt, rom, rto, rtd, rnw);
            model(rom, rto, rtd, rnw);
            compare_model($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/panzoom_seq.md
PANZOOM_SEQ -- requirements
Module: panzoom_seq

Interface
REQ-001 Parameter MEMAW, default 10, log2 of capture buffer depth per pass.
REQ-002 Parameter SETTLE, default 3, cycles the config is held stable before the arm pulse (minimum 2).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  input  1  capture request.
REQ-006 cmd_ready  output  1  high only in IDLE.
REQ-007 cmd_navr  input  6  averaging exponent.
REQ-008 cmd_dt  input  32  post-trigger delay, in cycles.
REQ-009 cmd_opmask  input  3  passes to run: bit0 mean, bit1 min, bit2 max.
REQ-010 cmd_timeout  input  32  trigger wait limit in cycles; 0 means wait forever.
REQ-011 abort  input  1  synchronous cancel.
REQ-012 pz_reset, pz_navr[6], pz_dt[32], pz_opsel[3]  outputs  datapath control.
REQ-013 pz_gout, pz_addrcnt[MEMAW], pz_stopped  inputs  datapath status.
REQ-014 wr_en  output  1  buffer write strobe.
REQ-015 wr_addr  output  MEMAW+2  buffer write address.
REQ-016 busy  output  1  high whenever not IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  2  status: 00 ok, 01 timeout, 10 aborted; held until next accepted command.

Function
REQ-019 FSM states SHALL be IDLE, SETTLE, ARM, WAIT_TRIG, RUN, NEXT, FIN.
REQ-020 Command acceptance SHALL occur on cmd_valid&cmd_ready: latch navr/dt/opmask/timeout, clear err and pass index, go to NEXT.
REQ-021 NEXT SHALL select the lowest set, not-yet-run opmask bit as pass p (0,1,2), set pz_opsel=p, then go to SETTLE; if no bits remain, go to FIN.
REQ-022 pz_navr and pz_dt SHALL be driven from the latched values and SHALL be stable from SETTLE entry until IDLE.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, then go to ARM.
REQ-024 ARM SHALL assert pz_reset for exactly one cycle (single rising edge), then go to WAIT_TRIG; pz_reset SHALL be 0 in all other states.
REQ-025 WAIT_TRIG SHALL go to RUN when pz_stopped==0.
REQ-026 WAIT_TRIG timeout: a 32-bit counter cleared at entry and incremented each cycle; when timeout!=0 and counter==timeout-1 with pz_stopped still 1, set err=01 and go to FIN, skipping remaining passes.
REQ-027 RUN SHALL go to NEXT on the first cycle with pz_stopped==1.
REQ-028 wr_en SHALL equal pz_gout while in RUN, 0 otherwise; wr_addr = {p[1:0], pz_addrcnt}, combinational from inputs and the pass register (zero added latency).
REQ-029 A pz_gout coinciding with the pz_stopped rise SHALL still be written.
REQ-030 FIN SHALL pulse done for one cycle, then go to IDLE.
REQ-031 opmask==0 SHALL produce NEXT->FIN->IDLE with done and err=00, with no pz_reset pulse.
REQ-032 abort SHALL have priority in every non-IDLE state: next state IDLE, err=10, no done, wr_en 0 from the following cycle; abort in IDLE SHALL be ignored.
REQ-033 cmd_valid while busy SHALL be ignored, not queued.

Reset
REQ-034 Asserted reset_n=0 SHALL immediately force: state IDLE; cmd_ready=1; busy=0; done=0; wr_en=0; pz_reset=0; pz_navr=0; pz_dt=0; pz_opsel=0; err=00; all counters 0.
REQ-035 Reset mid-capture SHALL discard the command; operation after reset release SHALL be identical to power-up.

Verification
REQ-036 navr=2, dt=5, opmask=001, MEMAW=4, trig 10 cycles after the arm pulse -> one pz_reset pulse, 16 wr_en with addresses 0..15, done once, err=00.
REQ-037 opmask=101 -> two arm pulses; pz_opsel 0 then 2; wr_addr upper bits 00 then 10; done after the second pass.
REQ-038 timeout=50, no trigger -> err=01 exactly 50 cycles after WAIT_TRIG entry; done pulses; no wr_en.
REQ-039 abort mid-RUN -> IDLE next cycle, err=10, no done; a new command is then accepted and completes normally.
REQ-040 reset_n low during RUN -> all outputs take reset values asynchronously (before the next clk edge); cmd_valid held during busy is not replayed.
REQ-041 opmask=000 -> done 2 cycles after acceptance, pz_reset never asserted.
